// File: rtl/wb_commit_ctrl.sv
`default_nettype none
// ============================================================================
// wb_commit_ctrl : writeback commit mux, in-order load-return FIFO, busy board
// Rev 1.0
// ============================================================================
module wb_commit_ctrl #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int LQ_DEPTH   = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          alu_valid,
   input  logic [ADDR_WIDTH-1:0]         alu_rd,
   input  logic [DATA_WIDTH-1:0]         alu_data,
   input  logic                          ld_issue,
   input  logic [ADDR_WIDTH-1:0]         ld_issue_rd,
   input  logic                          ld_valid,
   input  logic [ADDR_WIDTH-1:0]         ld_rd,
   input  logic [DATA_WIDTH-1:0]         ld_data,
   output logic                          ld_ready,
   input  logic [ADDR_WIDTH-1:0]         chk_rs1,
   input  logic [ADDR_WIDTH-1:0]         chk_rs2,
   input  logic [ADDR_WIDTH-1:0]         chk_rd,
   output logic                          hazard,
   output logic [(1<<ADDR_WIDTH)-1:0]    busy_vec,
   output logic [$clog2(LQ_DEPTH):0]     lq_count,
   output logic                          wen,
   output logic [ADDR_WIDTH-1:0]         waddr,
   output logic [DATA_WIDTH-1:0]         wdata
);

   localparam int                  c_nreg  = 1 << ADDR_WIDTH;
   localparam int                  c_ptr_w = $clog2(LQ_DEPTH);
   localparam int                  c_cnt_w = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0]  c_full  = c_cnt_w'(LQ_DEPTH);
   localparam logic [c_cnt_w-1:0]  c_one   = c_cnt_w'(1);
   localparam logic [c_ptr_w-1:0]  c_pone  = c_ptr_w'(1);

   logic [ADDR_WIDTH-1:0] r_lq_rd   [LQ_DEPTH];
   logic [DATA_WIDTH-1:0] r_lq_data [LQ_DEPTH];
   logic [c_ptr_w-1:0]    r_wr_ptr;
   logic [c_ptr_w-1:0]    r_rd_ptr;
   logic [c_cnt_w-1:0]    r_count;
   logic [c_nreg-1:0]     r_busy;

   logic                  w_empty;
   logic                  w_full;
   logic                  w_ld_ready;
   logic                  w_push;
   logic                  w_pop;
   logic [ADDR_WIDTH-1:0] w_head_rd;
   logic [DATA_WIDTH-1:0] w_head_data;
   logic                  w_sel_vld;
   logic [ADDR_WIDTH-1:0] w_sel_rd;
   logic [DATA_WIDTH-1:0] w_sel_data;
   logic [c_nreg-1:0]     w_busy_nxt;

   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == c_full);
   assign w_ld_ready  = rst_n & ~w_full;
   assign w_push      = ld_valid & w_ld_ready;
   // ALU results are never stalled, so the FIFO only drains on ALU-idle cycles
   assign w_pop       = rst_n & ~alu_valid & ~w_empty;
   assign w_head_rd   = r_lq_rd[r_rd_ptr];
   assign w_head_data = r_lq_data[r_rd_ptr];

   always_comb begin
      w_sel_vld  = 1'b0;
      w_sel_rd   = '0;
      w_sel_data = '0;
      if (rst_n && alu_valid) begin
         w_sel_vld  = 1'b1;
         w_sel_rd   = alu_rd;
         w_sel_data = alu_data;
      end else if (w_pop) begin
         w_sel_vld  = 1'b1;
         w_sel_rd   = w_head_rd;
         w_sel_data = w_head_data;
      end
   end

   assign wen      = w_sel_vld & (w_sel_rd != '0);
   assign waddr    = w_sel_rd;
   assign wdata    = w_sel_data;
   assign ld_ready = w_ld_ready;
   assign lq_count = rst_n ? r_count : '0;
   assign busy_vec = r_busy;
   assign hazard   = rst_n & (r_busy[chk_rs1] | r_busy[chk_rs2] | r_busy[chk_rd]);

   // Set after clear so a same-cycle reissue of the popped rd stays busy
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_pop) begin
         w_busy_nxt[w_head_rd] = 1'b0;
      end
      if (ld_issue && (ld_issue_rd != '0)) begin
         w_busy_nxt[ld_issue_rd] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_busy   <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_pone;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_pone;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_one;
            2'b01:   r_count <= r_count - c_one;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_lq_rd[r_wr_ptr]   <= ld_rd;
         r_lq_data[r_wr_ptr] <= ld_data;
      end
   end

   a_alu_rd_not_busy : assert property (
      @(posedge clk) disable iff (!rst_n) alu_valid |-> !r_busy[alu_rd]
   );

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_ctrl.sv
`default_nettype none
// ============================================================================
// tb_wb_commit_ctrl : directed vectors for the writeback commit controller
// Rev 1.0
// ============================================================================
module tb_wb_commit_ctrl;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int LQ = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          alu_valid;
   logic [AW-1:0] alu_rd;
   logic [DW-1:0] alu_data;
   logic          ld_issue;
   logic [AW-1:0] ld_issue_rd;
   logic          ld_valid;
   logic [AW-1:0] ld_rd;
   logic [DW-1:0] ld_data;
   logic          ld_ready;
   logic [AW-1:0] chk_rs1;
   logic [AW-1:0] chk_rs2;
   logic [AW-1:0] chk_rd;
   logic          hazard;
   logic [31:0]   busy_vec;
   logic [1:0]    lq_count;
   logic          wen;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_commit_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LQ_DEPTH(LQ)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .alu_valid  (alu_valid),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .ld_issue   (ld_issue),
      .ld_issue_rd(ld_issue_rd),
      .ld_valid   (ld_valid),
      .ld_rd      (ld_rd),
      .ld_data    (ld_data),
      .ld_ready   (ld_ready),
      .chk_rs1    (chk_rs1),
      .chk_rs2    (chk_rs2),
      .chk_rd     (chk_rd),
      .hazard     (hazard),
      .busy_vec   (busy_vec),
      .lq_count   (lq_count),
      .wen        (wen),
      .waddr      (waddr),
      .wdata      (wdata)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      alu_valid   = 1'b0;
      alu_rd      = '0;
      alu_data    = '0;
      ld_issue    = 1'b0;
      ld_issue_rd = '0;
      ld_valid    = 1'b0;
      ld_rd       = '0;
      ld_data     = '0;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      idle();
      chk_rs1 = '0;
      chk_rs2 = '0;
      chk_rd  = '0;

      // reset: outputs forced low even with live inputs
      rst_n = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_FFFF;
      ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h33;
      smp();
      check("rst_wen", wen, 0);
      check("rst_waddr", waddr, 0);
      check("rst_wdata", wdata, 0);
      check("rst_ld_ready", ld_ready, 0);
      check("rst_lq_count", lq_count, 0);
      check("rst_hazard", hazard, 0);
      nxt(); smp();
      check("rst_busy_vec", busy_vec, 0);
      nxt(); rst_n = 1'b1; idle();

      // 1) ALU commit in the same cycle
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
      smp();
      check("t1_wen", wen, 1);
      check("t1_waddr", waddr, 5);
      check("t1_wdata", wdata, 32'hDEAD_BEEF);
      check("t1_ld_ready", ld_ready, 1);

      // 2) load to r7 with scoreboard hazard
      nxt(); idle(); ld_issue = 1'b1; ld_issue_rd = 5'd7; chk_rs1 = 5'd7;
      smp();
      check("t2_haz_issue", hazard, 0);
      nxt(); idle(); smp();
      check("t2_busy", busy_vec, 32'h0000_0080);
      check("t2_haz_c1", hazard, 1);
      nxt(); smp();
      check("t2_haz_c2", hazard, 1);
      nxt(); ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h1234;
      smp();
      check("t2_push_wen", wen, 0);
      check("t2_push_ready", ld_ready, 1);
      check("t2_push_haz", hazard, 1);
      nxt(); idle(); smp();
      check("t2_cnt", lq_count, 1);
      check("t2_wen", wen, 1);
      check("t2_waddr", waddr, 7);
      check("t2_wdata", wdata, 32'h1234);
      check("t2_haz_commit", hazard, 1);
      nxt(); smp();
      check("t2_busy_clr", busy_vec, 0);
      check("t2_haz_clr", hazard, 0);
      check("t2_cnt_clr", lq_count, 0);
      check("t2_idle_wen", wen, 0);
      chk_rs1 = '0;

      // 3) load held behind four ALU cycles
      nxt(); ld_issue = 1'b1; ld_issue_rd = 5'd9;
      nxt(); idle();
      ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'hA5A5;
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'd3;
      smp();
      check("t3_alu0_waddr", waddr, 3);
      check("t3_alu0_wdata", wdata, 3);
      for (int i = 0; i < 3; i++) begin
         nxt(); ld_valid = 1'b0; alu_rd = AW'(4 + i); alu_data = DW'(100 + i);
         smp();
         check("t3_alu_waddr", waddr, 64'(4 + i));
         check("t3_alu_cnt", lq_count, 1);
      end
      nxt(); alu_valid = 1'b0; smp();
      check("t3_ld_wen", wen, 1);
      check("t3_ld_waddr", waddr, 9);
      check("t3_ld_wdata", wdata, 32'hA5A5);
      nxt(); smp();
      check("t3_cnt", lq_count, 0);
      check("t3_busy", busy_vec, 0);

      // 4) FIFO full with three returns, in-order commit
      nxt(); idle(); ld_issue = 1'b1; ld_issue_rd = 5'd10;
      nxt(); ld_issue_rd = 5'd11;
      nxt(); ld_issue_rd = 5'd12;
      nxt(); idle(); chk_rs2 = 5'd11;
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'd1;
      ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'h1010;
      smp();
      check("t4_busy", busy_vec, 32'h0000_1C00);
      check("t4_haz_rs2", hazard, 1);
      check("t4_rdy0", ld_ready, 1);
      nxt(); chk_rs2 = '0; chk_rd = 5'd12; ld_rd = 5'd11; ld_data = 32'h1111;
      smp();
      check("t4_haz_rd", hazard, 1);
      check("t4_rdy1", ld_ready, 1);
      check("t4_cnt1", lq_count, 1);
      nxt(); chk_rd = '0; ld_rd = 5'd12; ld_data = 32'h1212;
      smp();
      check("t4_rdy_full", ld_ready, 0);
      check("t4_cnt_full", lq_count, 2);
      nxt(); smp();
      check("t4_cnt_hold", lq_count, 2);
      check("t4_rdy_hold", ld_ready, 0);
      nxt(); alu_valid = 1'b0; smp();
      check("t4_c0_waddr", waddr, 10);
      check("t4_c0_wdata", wdata, 32'h1010);
      check("t4_c0_rdy", ld_ready, 0);
      nxt(); smp();
      check("t4_c1_cnt", lq_count, 1);
      check("t4_c1_rdy", ld_ready, 1);
      check("t4_c1_waddr", waddr, 11);
      check("t4_c1_wdata", wdata, 32'h1111);
      nxt(); ld_valid = 1'b0; smp();
      check("t4_c2_cnt", lq_count, 1);
      check("t4_c2_waddr", waddr, 12);
      check("t4_c2_wdata", wdata, 32'h1212);
      nxt(); smp();
      check("t4_cnt_end", lq_count, 0);
      check("t4_busy_end", busy_vec, 0);
      check("t4_wen_end", wen, 0);

      // 5) rd=0 commits never write
      nxt(); idle(); alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hBAD;
      smp();
      check("t5_alu_wen", wen, 0);
      nxt(); idle(); ld_issue = 1'b1; ld_issue_rd = 5'd0;
      ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h55;
      smp();
      check("t5_push_wen", wen, 0);
      nxt(); idle(); smp();
      check("t5_cnt1", lq_count, 1);
      check("t5_pop_wen", wen, 0);
      check("t5_busy", busy_vec, 0);
      nxt(); smp();
      check("t5_cnt0", lq_count, 0);

      // 6) reset with two entries queued
      nxt(); ld_issue = 1'b1; ld_issue_rd = 5'd13;
      nxt(); ld_issue_rd = 5'd14;
      nxt(); idle(); alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'd2;
      ld_valid = 1'b1; ld_rd = 5'd13; ld_data = 32'h1313;
      nxt(); ld_rd = 5'd14; ld_data = 32'h1414;
      nxt(); ld_valid = 1'b0; smp();
      check("t6_cnt", lq_count, 2);
      check("t6_busy", busy_vec, 32'h0000_6000);
      nxt(); rst_n = 1'b0; idle(); smp();
      check("t6_rst_wen", wen, 0);
      check("t6_rst_cnt", lq_count, 0);
      nxt(); rst_n = 1'b1; smp();
      check("t6_cnt_after", lq_count, 0);
      check("t6_busy_after", busy_vec, 0);
      check("t6_wen_after", wen, 0);
      nxt(); smp();
      check("t6_wen_after2", wen, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
